// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter
//   Round-robin write controller for a bank of level-sensitive D-latch words.
//   One requester is served per write sequence. Its address and data are
//   captured in IDLE, and the bank is then driven through a fixed sequence:
//   SETUP (data stable, no enable), ENABLE (one enable high for EN_CYC
//   cycles) and HOLD (enable low, data still stable, grant pulse). The latch
//   inputs therefore never change while a latch is transparent.
//
// Parameters
//   N_REQ  : number of requesters (2..8)
//   DW     : data word width
//   AW     : word address width; the bank has 2**AW words
//   EN_CYC : cycles the selected latch enable stays high (>= 1)
//
// Ports
//   clk     : clock; all state changes on the rising edge
//   rst     : synchronous active-high reset
//   req     : per-requester write request (level, held until gnt)
//   wdata   : requester i data at [i*DW +: DW]
//   waddr   : requester i word address at [i*AW +: AW]
//   gnt     : one-hot completion pulse, high for the HOLD cycle
//   bank_d  : data driven to every latch word
//   bank_le : one-hot latch enable, the "clock" of the latch words
//   busy    : high in every state except IDLE
module latch_bank_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DW     = 8,
  parameter int AW     = 2,
  parameter int EN_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*DW-1:0]  wdata,
  input  logic [N_REQ*AW-1:0]  waddr,
  output logic [N_REQ-1:0]     gnt,
  output logic [DW-1:0]        bank_d,
  output logic [(2**AW)-1:0]   bank_le,
  output logic                 busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = (EN_CYC > 1) ? $clog2(EN_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t              state;
  state_t              next_state;

  logic [IW-1:0]       last_winner;
  logic [IW-1:0]       win_idx;
  logic [AW-1:0]       cap_addr;
  logic [CW-1:0]       en_cnt;

  logic                arb_valid;
  logic [IW-1:0]       arb_idx;

  logic [N_REQ-1:0]    gnt_nxt;
  logic [(2**AW)-1:0]  bank_le_nxt;
  logic                busy_nxt;

  // Round-robin search: start one past the last winner and take the first
  // set request bit, wrapping from N_REQ-1 back to 0.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      if (!arb_valid && req[(int'(last_winner) + off) % N_REQ]) begin
        arb_valid = 1'b1;
        arb_idx   = IW'((int'(last_winner) + off) % N_REQ);
      end
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (arb_valid) next_state = SETUP;
      SETUP:   next_state = ENABLE;
      ENABLE:  if (en_cnt == '0) next_state = HOLD;
      HOLD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the next state. The results are registered below, so
  // bank_le and gnt come straight from flops and cannot glitch into the
  // latch enables.
  always_comb begin
    gnt_nxt     = '0;
    bank_le_nxt = '0;
    busy_nxt    = (next_state != IDLE);
    case (next_state)
      ENABLE:  bank_le_nxt[cap_addr] = 1'b1;
      HOLD:    gnt_nxt[win_idx]      = 1'b1;
      default: ;
    endcase
  end

  // Output flops and captured request. bank_d doubles as the captured data
  // register: it loads only on the IDLE->SETUP edge and is otherwise held.
  // NOTE: the capture registers are reset along with the control state,
  // because bank_d is a visible output with a defined reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt         <= '0;
      bank_le     <= '0;
      busy        <= 1'b0;
      bank_d      <= '0;
      cap_addr    <= '0;
      win_idx     <= '0;
      en_cnt      <= '0;
      last_winner <= IW'(N_REQ - 1);
    end else begin
      gnt     <= gnt_nxt;
      bank_le <= bank_le_nxt;
      busy    <= busy_nxt;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            win_idx  <= arb_idx;
            cap_addr <= waddr[int'(arb_idx)*AW +: AW];
            bank_d   <= wdata[int'(arb_idx)*DW +: DW];
          end
        end
        SETUP:   en_cnt <= CW'(EN_CYC - 1);
        ENABLE:  if (en_cnt != '0) en_cnt <= en_cnt - CW'(1);
        HOLD:    last_winner <= win_idx;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// tb_latch_bank_arbiter
//   Directed bench for latch_bank_arbiter with a mux-latch model of the bank.
//   Expected grants (requester, word address, data) are queued when a request
//   is driven and popped when a gnt pulse appears; the popped entry is
//   compared against gnt, bank_d and the modelled latch word.
module tb_latch_bank_arbiter;

  localparam int N_REQ  = 4;
  localparam int DW     = 8;
  localparam int AW     = 2;
  localparam int EN_CYC = 2;
  localparam int NW     = 2**AW;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] wdata;
  logic [N_REQ*AW-1:0] waddr;
  logic [N_REQ-1:0]    gnt;
  logic [DW-1:0]       bank_d;
  logic [NW-1:0]       bank_le;
  logic                busy;

  always #5 clk = ~clk;

  latch_bank_arbiter #(
    .N_REQ  (N_REQ),
    .DW     (DW),
    .AW     (AW),
    .EN_CYC (EN_CYC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wdata   (wdata),
    .waddr   (waddr),
    .gnt     (gnt),
    .bank_d  (bank_d),
    .bank_le (bank_le),
    .busy    (busy)
  );

  // Mux-based D-latch words: transparent while their enable is high.
  logic [DW-1:0] mem [NW];
  always_latch begin
    for (int i = 0; i < NW; i++) begin
      if (bank_le[i]) mem[i] <= bank_d;
    end
  end

  typedef struct {
    int            idx;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    exp_t e;
    e.idx  = idx;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic set_word(input int i, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    waddr[i*AW +: AW] = addr;
    wdata[i*DW +: DW] = data;
  endtask

  // One clock: sample 1 time unit after the rising edge, check invariants,
  // and retire a scoreboard entry whenever a grant pulse is visible.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    check("le_onehot0", 32'($onehot0(bank_le)), 32'd1);
    check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    check("le_gnt_excl", 32'((bank_le != '0) && (gnt != '0)), 32'd0);
    if (gnt != '0) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("gnt_idx", 32'(gnt), 32'(1 << e.idx));
        check("latch_word", 32'(mem[e.addr]), 32'(e.data));
        check("bank_d_at_gnt", 32'(bank_d), 32'(e.data));
      end
    end
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt == '0 && n < 20);
    check("gnt_wait", 32'(gnt != '0), 32'd1);
  endtask

  int              n;
  int              prev;
  logic [N_REQ-1:0] dropped;
  int              order [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    // ---------------- reset defaults with random requests
    rst   = 1'b1;
    req   = 4'($urandom);
    wdata = $urandom;
    waddr = 8'($urandom);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_le", 32'(bank_le), 32'd0);
      check("rst_bank_d", 32'(bank_d), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      req = 4'($urandom);
    end
    rst = 1'b0;
    req = '0;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_le", 32'(bank_le), 32'd0);

    // ---------------- round-robin wrap, all four requesting
    for (int i = 0; i < N_REQ; i++) set_word(i, AW'(i), DW'(8'h10 + i));
    for (int k = 0; k < 6; k++) push(order[k], AW'(order[k]), DW'(8'h10 + order[k]));
    req  = '1;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      wait_gnt(n);
      if (k == 0) check("rr_first_latency", 32'(n), 32'(EN_CYC + 2));
      else        check("rr_spacing", 32'(cyc - prev), 32'(EN_CYC + 3));
      prev    = cyc;
      dropped = gnt;
      req     = req & ~gnt;
      tick();
      check("rr_idle_busy", 32'(busy), 32'd0);
      if (k < 5) req = req | dropped;
      else       req = '0;
    end

    // ---------------- single write: requester 2, word 3, 8'hA5
    set_word(2, 2'd3, 8'hA5);
    push(2, 2'd3, 8'hA5);
    req = 4'b0100;
    tick();
    check("sw_setup_d", 32'(bank_d), 32'hA5);
    check("sw_setup_le", 32'(bank_le), 32'd0);
    check("sw_setup_busy", 32'(busy), 32'd1);
    tick();
    check("sw_en1_le", 32'(bank_le), 32'b1000);
    check("sw_en1_gnt", 32'(gnt), 32'd0);
    tick();
    check("sw_en2_le", 32'(bank_le), 32'b1000);
    tick();
    check("sw_hold_gnt", 32'(gnt), 32'b0100);
    check("sw_hold_le", 32'(bank_le), 32'd0);
    req = '0;
    tick();
    check("sw_idle_gnt", 32'(gnt), 32'd0);
    check("sw_idle_busy", 32'(busy), 32'd0);
    check("sw_word3", 32'(mem[3]), 32'hA5);

    // ---------------- data stability: inputs change while the enable is high
    set_word(0, 2'd1, 8'h3C);
    push(0, 2'd1, 8'h3C);
    req = 4'b0001;
    tick();
    check("ds_setup_d", 32'(bank_d), 32'h3C);
    tick();
    set_word(0, 2'd2, 8'hC3);
    check("ds_en1_le", 32'(bank_le), 32'b0010);
    check("ds_en1_d", 32'(bank_d), 32'h3C);
    tick();
    check("ds_en2_le", 32'(bank_le), 32'b0010);
    check("ds_en2_d", 32'(bank_d), 32'h3C);
    tick();
    check("ds_hold_gnt", 32'(gnt), 32'b0001);
    req = '0;
    tick();
    check("ds_idle_d", 32'(bank_d), 32'h3C);
    check("ds_word1", 32'(mem[1]), 32'h3C);
    check("ds_word2_untouched", 32'(mem[2]), 32'h12);

    // ---------------- early drop: requester 1 drops req in SETUP
    set_word(1, 2'd0, 8'h5A);
    push(1, 2'd0, 8'h5A);
    req = 4'b0010;
    tick();
    req = '0;
    tick();
    check("ed_en_le", 32'(bank_le), 32'b0001);
    wait_gnt(n);
    check("ed_gnt", 32'(gnt), 32'b0010);
    check("ed_gnt_latency", 32'(n), 32'd2);
    tick();
    check("ed_idle_busy", 32'(busy), 32'd0);

    // ---------------- reset during the first ENABLE cycle
    set_word(0, 2'd3, 8'h77);
    req = 4'b0001;
    tick();
    tick();
    check("mr_en_le", 32'(bank_le), 32'b1000);
    rst = 1'b1;
    tick();
    check("mr_le", 32'(bank_le), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_gnt", 32'(gnt), 32'd0);
    check("mr_bank_d", 32'(bank_d), 32'd0);
    rst = 1'b0;
    set_word(0, 2'd2, 8'h99);
    set_word(1, 2'd1, 8'h66);
    push(0, 2'd2, 8'h99);
    req = 4'b0011;
    wait_gnt(n);
    check("mr_first_winner", 32'(gnt), 32'b0001);
    check("mr_latency", 32'(n), 32'(EN_CYC + 2));
    push(1, 2'd1, 8'h66);
    req = 4'b0010;
    wait_gnt(n);
    check("mr_second_winner", 32'(gnt), 32'b0010);
    req = '0;
    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
